// File: rtl/div_share_ctrl.sv
// -----------------------------------------------------------------------------
// div_share_ctrl
//
// Shares one combinational 7-bit / 4-bit array divider between two requesters.
// A grant latches the winner's operands onto the divider inputs. They are held
// for SETTLE_CYCLES cycles while the ripple chain settles. The quotient and
// remainder are then registered and returned with a one-cycle ack. Operand
// pairs whose quotient cannot fit in 4 bits, and divide-by-zero, are answered
// immediately with err=1 and never wait on the divider.
//
// Optional feature: define DIV_SHARE_STATS_EN to add the op_count/err_count
// statistics outputs.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req0/dvd0/dvs0    requester 0: level request (held until ack0), operands
//   req1/dvd1/dvs1    requester 1: level request (held until ack1), operands
//   ack0, ack1        one-cycle result-valid pulses (never both high)
//   quo, rem, err     registered result; held until the next response
//   busy              high whenever the sequencer is not idle
//   div_D, div_d      registered dividend/divisor driven to the divider
//   div_q, div_r      quotient/remainder returned by the divider
//   op_count          (DIV_SHARE_STATS_EN) responses with err=0, wraps at 255
//   err_count         (DIV_SHARE_STATS_EN) responses with err=1, wraps at 255
// -----------------------------------------------------------------------------
module div_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 3   // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [6:0] dvd0,
    input  logic [3:0] dvs0,
    input  logic       req1,
    input  logic [6:0] dvd1,
    input  logic [3:0] dvs1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] quo,
    output logic [3:0] rem,
    output logic       err,
    output logic       busy,
    output logic [6:0] div_D,
    output logic [3:0] div_d,
    input  logic [3:0] div_q,
    input  logic [3:0] div_r
`ifdef DIV_SHARE_STATS_EN
    ,
    output logic [7:0] op_count,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       ptr_q,   ptr_d;     // preferred requester when both request
    logic       gid_q,   gid_d;     // id of the requester being served
    logic [6:0] dvd_q,   dvd_d;
    logic [3:0] dvs_q,   dvs_d;
    logic [3:0] quo_q,   quo_d;
    logic [3:0] rem_q,   rem_d;
    logic       err_q,   err_d;
    logic       ack0_q,  ack0_d;
    logic       ack1_q,  ack1_d;

    // Arbitration: requester 1 wins if it is alone, or if both request and
    // the pointer prefers it.
    logic       gnt1;
    logic [6:0] sel_dvd;
    logic [3:0] sel_dvs;
    logic [7:0] dvs_x16;
    logic       err_cond;

    assign gnt1    = req1 & (~req0 | ptr_q);
    assign sel_dvd = gnt1 ? dvd1 : dvd0;
    assign sel_dvs = gnt1 ? dvs1 : dvs0;

    // The quotient fits in 4 bits only when dividend < divisor*16. The 8-bit
    // product cannot overflow (max 15*16 = 240).
    assign dvs_x16  = {sel_dvs, 4'b0000};
    assign err_cond = (sel_dvs == 4'd0) | ({1'b0, sel_dvd} >= dvs_x16);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gid_d = gnt1;
                    ptr_d = ~gnt1;        // the loser is preferred next time
                    dvd_d = sel_dvd;
                    dvs_d = sel_dvs;
                    if (err_cond) begin
                        // Respond at once; the divider output is never used.
                        quo_d   = 4'd0;
                        rem_d   = 4'd0;
                        err_d   = 1'b1;
                        ack0_d  = ~gnt1;
                        ack1_d  = gnt1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end
                end
            end

            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    quo_d   = div_q;
                    rem_d   = div_r;
                    err_d   = 1'b0;
                    ack0_d  = ~gid_q;
                    ack1_d  = gid_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            RESP: begin
                // Always passes through IDLE so the requester has a cycle
                // to drop its level request before it is sampled again.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b0;
            gid_q   <= 1'b0;
            dvd_q   <= 7'd0;
            dvs_q   <= 4'd0;
            quo_q   <= 4'd0;
            rem_q   <= 4'd0;
            err_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign quo   = quo_q;
    assign rem   = rem_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);
    assign div_D = dvd_q;
    assign div_d = dvs_q;

`ifdef DIV_SHARE_STATS_EN
    logic [7:0] op_cnt_q;
    logic [7:0] err_cnt_q;

    // One count per RESP cycle, split by the error flag being presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q  <= 8'd0;
            err_cnt_q <= 8'd0;
        end else if (state_q == RESP) begin
            if (err_q) err_cnt_q <= err_cnt_q + 8'd1;
            else       op_cnt_q  <= op_cnt_q + 8'd1;
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [6:0] dvd0, dvd1;
    logic [3:0] dvs0, dvs1;
    logic       ack0, ack1, err, busy;
    logic [3:0] quo, rem, div_d, div_q, div_r;
    logic [6:0] div_D;
`ifdef DIV_SHARE_STATS_EN
    logic [7:0] op_count, err_count;
    int         tb_ops, tb_errs;
`endif

    always #5 clk = ~clk;

    // Stand-in for the shared combinational array divider.
    assign div_q = (div_d == 4'd0) ? 4'd0 : 4'(div_D / div_d);
    assign div_r = (div_d == 4'd0) ? 4'd0 : 4'(div_D % div_d);

    div_share_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .dvd0(dvd0), .dvs0(dvs0),
        .req1(req1), .dvd1(dvd1), .dvs1(dvs1),
        .ack0(ack0), .ack1(ack1), .quo(quo), .rem(rem), .err(err), .busy(busy),
        .div_D(div_D), .div_d(div_d), .div_q(div_q), .div_r(div_r)
`ifdef DIV_SHARE_STATS_EN
        , .op_count(op_count), .err_count(err_count)
`endif
    );

    typedef struct {
        logic [6:0] a;
        logic [3:0] b;
        int         q;
        int         r;
        int         e;
    } exp_t;

    exp_t q0[$], q1[$];
    int   checks = 0, passes = 0;
    int   cyc = 0;
    bit   contention = 0;
    int   exp_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: a valid quotient must fit in 4 bits.
    function automatic exp_t model(input logic [6:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a; e.b = b;
        e.e = (b == 0 || int'(a) >= int'(b) * 16) ? 1 : 0;
        e.q = e.e ? 0 : int'(a) / int'(b);
        e.r = e.e ? 0 : int'(a) % int'(b);
        return e;
    endfunction

    // Monitor / scoreboard
    logic       busy_prev = 1'b0;
    int         g_cyc = 0;
    logic [6:0] gD;
    logic [3:0] gd;
    bit         unstable = 0;

    always @(negedge clk) begin : mon
        int   id;
        exp_t e;
        if (busy && !busy_prev) begin
            g_cyc = cyc; gD = div_D; gd = div_d; unstable = 0;
        end else if (busy && (div_D != gD || div_d != gd)) begin
            unstable = 1;
        end
        busy_prev = busy;
        if (ack0 || ack1) begin
            chk("ack_exclusive", int'(ack0 && ack1), 0);
            id = ack1 ? 1 : 0;
            if (contention) begin
                chk("rr_order", id, exp_id);
                exp_id ^= 1;
            end
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk("quo", int'(quo), e.q);
                chk("rem", int'(rem), e.r);
                chk("err", int'(err), e.e);
                // Counted with the cycle that starts at the grant edge as 1.
                chk("latency", cyc - g_cyc + 1, e.e ? 1 : S + 1);
                chk("div_D", int'(div_D), int'(e.a));
                chk("div_d", int'(div_d), int'(e.b));
                chk("operand_stable", int'(unstable), 0);
`ifdef DIV_SHARE_STATS_EN
                if (e.e != 0) tb_errs++; else tb_ops++;
`endif
            end
        end
    end

    task automatic do_req(input int id, input logic [6:0] a, input logic [3:0] b);
        exp_t e;
        bit   got;
        e = model(a, b);
        @(posedge clk) #1;
        if (id == 0) begin dvd0 = a; dvs0 = b; req0 = 1'b1; q0.push_back(e); end
        else         begin dvd1 = a; dvs1 = b; req1 = 1'b1; q1.push_back(e); end
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((id == 0) ? ack0 : ack1) begin got = 1; break; end
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge clk) #1;
        if (id == 0) begin req0 = 1'b0; dvd0 = 7'($urandom); dvs0 = 4'($urandom); end
        else         begin req1 = 1'b0; dvd1 = 7'($urandom); dvs1 = 4'($urandom); end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ack"}, int'({ack1, ack0}), 0);
        chk({tag, "_quo"}, int'(quo), 0);
        chk({tag, "_rem"}, int'(rem), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_divD"}, int'(div_D), 0);
        chk({tag, "_divd"}, int'(div_d), 0);
`ifdef DIV_SHARE_STATS_EN
        chk({tag, "_opcnt"}, int'(op_count), 0);
        chk({tag, "_errcnt"}, int'(err_count), 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk) #1 rst_n = 1'b0;
        @(posedge clk) #1 rst_n = 1'b1;
`ifdef DIV_SHARE_STATS_EN
        tb_ops = 0; tb_errs = 0;
`endif
    endtask

    task automatic rand_driver(input int id, input int n);
        logic [6:0] a;
        logic [3:0] b;
        int         sel;
        repeat (n) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            sel = $urandom_range(0, 7);
            b = 4'($urandom_range(1, 15));
            a = 7'($urandom_range(0, 127));
            case (sel)
                0: b = 4'd0;
                1: begin b = 4'($urandom_range(1, 7)); a = 7'(int'(b) * 16); end
                2: begin b = 4'($urandom_range(1, 8)); a = 7'(int'(b) * 16 - 1); end
                default: ;
            endcase
            do_req(id, a, b);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passes, checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        dvd0 = '0; dvs0 = '0; dvd1 = '0; dvs1 = '0;
`ifdef DIV_SHARE_STATS_EN
        tb_ops = 0; tb_errs = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset("reset");

        // Both requesters hammer the divider: grants must alternate from 0.
        contention = 1; exp_id = 0;
        fork
            repeat (4) do_req(0, 7'($urandom), 4'($urandom));
            repeat (4) do_req(1, 7'($urandom), 4'($urandom));
        join
        contention = 0;

        do_req(0, 7'd100, 4'd7);
        do_req(1, 7'd50,  4'd0);
        do_req(0, 7'd112, 4'd7);
        do_req(1, 7'd111, 4'd7);
        do_req(0, 7'd127, 4'd8);

        // Reset in the middle of SETTLE; the held request is served again.
        fork
            do_req(0, 7'd100, 4'd7);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (busy) break;
                end
                @(posedge clk) #1 rst_n = 1'b0;
                @(posedge clk) #1 rst_n = 1'b1;
`ifdef DIV_SHARE_STATS_EN
                tb_ops = 0; tb_errs = 0;
`endif
                check_reset("mid_settle");
            end
        join

        fork
            rand_driver(0, 30);
            rand_driver(1, 30);
        join

`ifdef DIV_SHARE_STATS_EN
        chk("op_count_run", int'(op_count), tb_ops % 256);
        chk("err_count_run", int'(err_count), tb_errs % 256);
        do_reset();
        do_req(0, 7'd100, 4'd7);
        do_req(1, 7'd9,   4'd0);
        do_req(0, 7'd111, 4'd7);
        do_req(1, 7'd127, 4'd7);
        do_req(0, 7'd127, 4'd8);
        @(posedge clk) #1;
        chk("op_count_3", int'(op_count), 3);
        chk("err_count_2", int'(err_count), 2);
        do_reset();
        repeat (256) do_req(0, 7'd100, 4'd7);
        @(posedge clk) #1;
        chk("op_count_wrap", int'(op_count), 0);
`endif

        repeat (3) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
